// File: rtl/line_arbiter_if.sv
// Bundle between line_arbiter, its NREQ requesters and the shared byte-stream core.
interface line_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    // Handshake: byte i moves on a rising clk edge where req_valid[i] and
    // req_ready[i] are both high. req_valid must not wait for req_ready, and
    // req_data must hold steady while req_valid is high and the byte has not
    // moved. core_in/core_out/out_data use 8'h00 as "no byte" instead of a valid.
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        core_in;
    logic [7:0]        core_out;
    logic              out_valid;
    logic [7:0]        out_data;
    logic [IDW-1:0]    out_id;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, core_out,
        output req_ready, core_in, out_valid, out_data, out_id, busy
    );

    // Requester/core side
    modport master (
        output req_valid, req_data, core_out,
        input  req_ready, core_in, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/line_arbiter.sv
// Round-robin line arbiter: grants one requester the text core for a whole
// line, waits for the core to go quiet, then passes the core to the next one.
module line_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int DRAIN  = 8,
    parameter int MAXLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    line_arbiter_if.slave bus,
    output logic [1:0]    dbg_state_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int LW = $clog2(MAXLEN);
    localparam int QW = $clog2(DRAIN + 1);
    localparam logic [LW-1:0] LEN_LAST = LW'(MAXLEN - 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(DRAIN - 1);

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  g_q, g_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [LW-1:0]   len_q, len_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [7:0]      core_in_q, core_in_d;
    logic            out_valid_q;
    logic [7:0]      out_data_q;
    logic [IDW-1:0]  out_id_q;
    logic [NREQ-1:0] ready_raw;
    logic            any_valid;
    logic [IDW-1:0]  pick;
    logic            sel_valid;
    logic [7:0]      sel_data;

    // Requester index that lies off positions after base, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NREQ;
        return IDW'(s);
    endfunction

    // Round-robin search: walk from the farthest offset down so the nearest
    // valid requester after last_q is the one left in pick.
    always_comb begin
        any_valid = 1'b0;
        pick      = last_q;
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req_valid[rr_idx(last_q, i)]) begin
                any_valid = 1'b1;
                pick      = rr_idx(last_q, i);
            end
        end
    end

    assign sel_valid = bus.req_valid[g_q];
    assign sel_data  = bus.req_data[{g_q, 3'b000} +: 8];

    // Next-state logic: grant in IDLE, forward one line in SEND, wait for quiet core in DRAIN.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        len_d     = len_q;
        qcnt_d    = qcnt_q;
        core_in_d = 8'h00;
        ready_raw = '0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    g_d     = pick;
                    len_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // At the length limit a real newline is still forwarded as the
                // last byte; anything else is held back and a newline injected.
                if (len_q == LEN_LAST && !(sel_valid && sel_data == 8'h0A)) begin
                    core_in_d = 8'h0A;
                    qcnt_d    = '0;
                    state_d   = S_DRAIN;
                end else if (sel_valid) begin
                    ready_raw[g_q] = 1'b1;
                    core_in_d      = sel_data;
                    if (sel_data != 8'h00) begin
                        len_d = len_q + 1'b1;
                    end
                    if (sel_data == 8'h0A) begin
                        qcnt_d  = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.core_out != 8'h00) begin
                    qcnt_d = '0;
                end else if (qcnt_q == Q_LAST) begin
                    qcnt_d  = '0;
                    last_d  = g_q;
                    state_d = S_IDLE;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; reset abandons any line in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            last_q    <= IDW'(NREQ - 1);
            len_q     <= '0;
            qcnt_q    <= '0;
            core_in_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            len_q     <= len_d;
            qcnt_q    <= qcnt_d;
            core_in_q <= core_in_d;
        end
    end

    // Output path: register core output and tag it with the current line owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= (bus.core_out != 8'h00);
            out_data_q  <= bus.core_out;
            out_id_q    <= (state_q == S_IDLE) ? last_q : g_q;
        end
    end

    // No byte is reported consumed while reset is held.
    assign bus.req_ready = rst ? '0 : ready_raw;
    assign bus.core_in   = core_in_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_line_arbiter.sv
// Testbench for line_arbiter: directed line traffic, a line-level model of the
// expected core stream, a per-cycle compare process and literal spot checks.
module tb_line_arbiter;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int DRAIN  = 8;
    localparam int MAXLEN = 64;
    localparam int LOGN   = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    line_arbiter #(.NREQ(NREQ), .IDW(IDW), .DRAIN(DRAIN), .MAXLEN(MAXLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]     src_q [NREQ][$];
    logic [7:0]     mdl_q [NREQ][$];
    logic [7+IDW:0] exp_q [$];
    int             popped [NREQ];
    int             take_log [$];
    int             nz_val [$];
    int             nz_idx [$];

    logic [7:0]      log_core_in  [LOGN];
    logic [7:0]      log_core_out [LOGN];
    logic            log_busy     [LOGN];
    logic [NREQ-1:0] log_ready    [LOGN];
    logic [NREQ-1:0] log_valid    [LOGN];
    logic [1:0]      log_state    [LOGN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]        = (src_q[i].size() > 0);
            bus.req_data[8*i +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) src_q[r].push_back(s[i]);
        drive();
    endtask

    task automatic push_bytes(input int r, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) src_q[r].push_back(b);
        drive();
    endtask

    // Requester side: a byte leaves its queue after an edge where valid&ready held.
    initial begin : requester_proc
        logic [NREQ-1:0] drv_take;
        forever begin
            @(negedge clk);
            drv_take = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (drv_take[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    popped[i]++;
                end
            end
            drive();
        end
    end

    // Text core stand-in: uppercases letters, one edge between core_in and core_out.
    initial begin : core_proc
        logic [7:0] core_p1;
        core_p1      = 8'h00;
        bus.core_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.core_out = core_p1;
            core_p1      = upcase(bus.core_in);
        end
    end

    // ---------------- line-level model ----------------
    task automatic mdl_load(input int r, input string s);
        for (int i = 0; i < s.len(); i++) mdl_q[r].push_back(s[i]);
    endtask

    task automatic mdl_load_n(input int r, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) mdl_q[r].push_back(b);
    endtask

    // Turn the loaded requester streams into the expected (owner, byte) core stream:
    // whole lines, round-robin after start_last, zero bytes dropped, a newline
    // injected once MAXLEN-1 bytes of a line have gone without one.
    task automatic mdl_run(input int start_last);
        int last;
        int g;
        int cnt;
        logic [7:0] b;
        last = start_last;
        while (1) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && mdl_q[(last + k) % NREQ].size() > 0) g = (last + k) % NREQ;
            if (g < 0) break;
            cnt = 0;
            while (1) begin
                if (cnt == MAXLEN - 1) begin
                    if (mdl_q[g].size() > 0 && mdl_q[g][0] == 8'h0A) void'(mdl_q[g].pop_front());
                    exp_q.push_back({IDW'(g), 8'h0A});
                    break;
                end
                if (mdl_q[g].size() == 0) break;
                b = mdl_q[g].pop_front();
                if (b == 8'h00) continue;
                exp_q.push_back({IDW'(g), b});
                cnt++;
                if (b == 8'h0A) break;
            end
            last = g;
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin : compare_proc
        logic [NREQ-1:0] tk;
        logic [7+IDW:0]  cur;
        logic [7+IDW:0]  dly1;
        logic [7+IDW:0]  dly2;
        int skip_out;
        dly1 = '0;
        dly2 = '0;
        skip_out = 4;
        forever begin
            @(negedge clk);
            if (cyc < LOGN) begin
                log_core_in[cyc]  = bus.core_in;
                log_core_out[cyc] = bus.core_out;
                log_busy[cyc]     = bus.busy;
                log_ready[cyc]    = bus.req_ready;
                log_valid[cyc]    = bus.req_valid;
                log_state[cyc]    = dbg_state;
            end
            tk = bus.req_ready & bus.req_valid;
            for (int i = 0; i < NREQ; i++) if (tk[i]) take_log.push_back(i);
            check("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
            check("ready_without_valid", bus.req_ready & ~bus.req_valid, 0);
            cur = '0;
            if (bus.core_in != 8'h00) begin
                if (exp_q.size() == 0) check("core_in_unexpected", bus.core_in, 0);
                else begin
                    cur = exp_q.pop_front();
                    check("core_in", bus.core_in, cur[7:0]);
                end
            end
            if (rst) skip_out = 4;
            if (skip_out > 0) skip_out--;
            else begin
                check("out_valid", bus.out_valid, (dly2[7:0] != 8'h00));
                check("out_data", bus.out_data, upcase(dly2[7:0]));
                if (dly2[7:0] != 8'h00) check("out_id", bus.out_id, dly2[8 +: IDW]);
            end
            dly2 = dly1;
            dly1 = cur;
        end
    end

    // ---------------- test helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_in", bus.core_in, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_id", bus.out_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic bit all_src_empty();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(all_src_empty() && exp_q.size() == 0 && !bus.busy)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n < budget), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_popped(input int r, input int target, input string name);
        int n;
        n = 0;
        while (popped[r] < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_timeout"}, (n < 200), 1);
    endtask

    task automatic collect(input int from, input int upto);
        nz_val.delete();
        nz_idx.delete();
        for (int i = from; i < upto && i < LOGN; i++) begin
            if (log_core_in[i] != 8'h00) begin
                nz_val.push_back(int'(log_core_in[i]));
                nz_idx.push_back(i);
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim_proc
        int t0;
        int s;
        int last_nz;
        int n;
        int rr_exp [6];
        int ab_exp [6];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        ab_exp = '{8'h61, 8'h62, 8'h0A, 8'h61, 8'h62, 8'h0A};
        for (int i = 0; i < NREQ; i++) popped[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        drive();

        // Single line "xyz\n" from requester 0
        do_reset();
        @(posedge clk);
        #1;
        t0 = cyc;
        mdl_load(0, "xyz\n");
        mdl_run(NREQ - 1);
        push_str(0, "xyz\n");
        wait_done("single", 400);
        check("single_b0", log_core_in[t0 + 2], 8'h78);
        check("single_b1", log_core_in[t0 + 3], 8'h79);
        check("single_b2", log_core_in[t0 + 4], 8'h7A);
        check("single_b3", log_core_in[t0 + 5], 8'h0A);
        check("single_pre", log_core_in[t0 + 1], 8'h00);
        last_nz = t0;
        for (int i = t0; i < cyc && i < LOGN; i++) if (log_core_out[i] != 8'h00) last_nz = i;
        check("single_busy_hold", log_busy[last_nz + DRAIN], 1);
        check("single_busy_fall", log_busy[last_nz + DRAIN + 1], 0);

        // Contention: requesters 0 and 2 together, each "ab\n"
        do_reset();
        @(posedge clk);
        #1;
        t0 = cyc;
        mdl_load(0, "ab\n");
        mdl_load(2, "ab\n");
        mdl_run(NREQ - 1);
        push_str(0, "ab\n");
        push_str(2, "ab\n");
        wait_done("contend", 400);
        collect(t0, cyc);
        check("contend_count", nz_val.size(), 6);
        if (nz_val.size() == 6) begin
            for (int i = 0; i < 6; i++) check("contend_byte", nz_val[i], ab_exp[i]);
            check("contend_gap", ((nz_idx[3] - nz_idx[2] - 1) >= DRAIN + 1), 1);
        end

        // Round-robin with one-byte lines
        do_reset();
        @(posedge clk);
        #1;
        s = take_log.size();
        mdl_load(0, "\n\n");
        mdl_load(1, "\n\n");
        mdl_load(2, "\n");
        mdl_load(3, "\n");
        mdl_run(NREQ - 1);
        push_str(0, "\n\n");
        push_str(1, "\n\n");
        push_str(2, "\n");
        push_str(3, "\n");
        wait_done("rr", 600);
        check("rr_count", take_log.size() - s, 6);
        if (take_log.size() - s == 6)
            for (int i = 0; i < 6; i++) check("rr_order", take_log[s + i], rr_exp[i]);

        // Overflow: 70 bytes of 'A' then a newline from requester 1
        do_reset();
        @(posedge clk);
        #1;
        t0 = cyc;
        n = popped[1];
        mdl_load_n(1, 8'h41, 70);
        mdl_load(1, "\n");
        mdl_run(NREQ - 1);
        push_bytes(1, 8'h41, 70);
        push_str(1, "\n");
        wait_done("ovf", 1000);
        collect(t0, cyc);
        check("ovf_count", nz_val.size(), 72);
        check("ovf_popped", popped[1] - n, 71);
        if (nz_val.size() == 72) begin
            check("ovf_first", nz_val[0], 8'h41);
            check("ovf_b62", nz_val[62], 8'h41);
            check("ovf_inject", nz_val[63], 8'h0A);
            check("ovf_ready_low", log_ready[nz_idx[63] - 1][1], 0);
            check("ovf_valid_held", log_valid[nz_idx[63] - 1][1], 1);
            check("ovf_rest0", nz_val[64], 8'h41);
            check("ovf_rest6", nz_val[70], 8'h41);
            check("ovf_end", nz_val[71], 8'h0A);
        end

        // Bubbles and a zero byte inside one line
        do_reset();
        @(posedge clk);
        #1;
        t0 = cyc;
        n = popped[0];
        mdl_load(0, "q");
        mdl_load_n(0, 8'h00, 1);
        mdl_load(0, "\n");
        mdl_run(NREQ - 1);
        push_str(0, "q");
        wait_popped(0, n + 1, "bubble_q");
        repeat (3) @(posedge clk);
        #1;
        push_bytes(0, 8'h00, 1);
        push_str(0, "\n");
        wait_done("bubble", 400);
        check("bubble_popped", popped[0] - n, 3);
        collect(t0, cyc);
        check("bubble_count", nz_val.size(), 2);
        if (nz_val.size() == 2) begin
            check("bubble_b0", log_core_in[nz_idx[0]], 8'h71);
            for (int i = 1; i <= 4; i++) check("bubble_zero", log_core_in[nz_idx[0] + i], 8'h00);
            check("bubble_nl", log_core_in[nz_idx[0] + 5], 8'h0A);
            for (int i = 0; i <= 4; i++) check("bubble_in_send", log_state[nz_idx[0] + i], 1);
        end

        // Reset in the middle of "xyz\n" from requester 2
        do_reset();
        @(posedge clk);
        #1;
        n = popped[2];
        exp_q.push_back({IDW'(2), 8'h78});
        exp_q.push_back({IDW'(2), 8'h79});
        push_str(2, "xyz\n");
        wait_popped(2, n + 2, "midrst_xy");
        t0 = cyc;
        s = take_log.size();
        rst = 1'b1;
        push_str(0, "k\n");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_load(0, "k\n");
        mdl_load(2, "z\n");
        mdl_run(NREQ - 1);
        wait_done("midrst", 400);
        check("midrst_core_in_zero", log_core_in[t0 + 1], 8'h00);
        check("midrst_takes", take_log.size() - s, 4);
        if (take_log.size() > s) check("midrst_next_grant", take_log[s], 0);
        check("midrst_popped", popped[2] - n, 4);

        check("exp_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net in case some wait above never returns.
    initial begin : watchdog_proc
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
